// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned STATE_W = 2;
   localparam int unsigned PC_STEP = 4;

   localparam logic [XLEN-1:0] NOP_WORD_DEF = 32'h0000_0000;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      OUT  = 2'd3
   } fetch_state_t;

   // Force an address onto a word boundary.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_if;
   import fetch_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   modport master (output imem_req, imem_addr,
                   input  imem_gnt, imem_rvalid, imem_rdata);

   modport slave  (input  imem_req, imem_addr,
                   output imem_gnt, imem_rvalid, imem_rdata);

endinterface

// File: rtl/fetch_pc_next.sv
// Next-PC candidates (sequential and aligned redirect) plus misaligned-target detect.
module fetch_pc_next
   import fetch_pkg::*;
(
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_branch_taken,
   input  logic [XLEN-1:0] i_branch_target,
   output logic [XLEN-1:0] o_pc_seq_c,
   output logic [XLEN-1:0] o_pc_target_c,
   output logic            o_misalign_c
);

   // Modulo-2^32 sequential step and word-aligned redirect target.
   always_comb begin
      o_pc_seq_c    = i_pc + XLEN'(PC_STEP);
      o_pc_target_c = align_word(i_branch_target);
      o_misalign_c  = i_branch_taken & (|i_branch_target[1:0]);
   end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding imem
// fetches, presents instructions to decode and squashes wrong-path responses.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             branch_taken,
   input  logic [XLEN-1:0]  branch_target,
   input  logic             stall,
   fetch_if.master          imem,
   output logic             if_valid,
   output logic [XLEN-1:0]  if_instr,
   output logic [XLEN-1:0]  if_pc,
   output logic [XLEN-1:0]  if_pc_plus4,
   output logic             misalign_err
);

   fetch_state_t    r_state, w_state_nxt;
   logic [XLEN-1:0] r_pc, w_pc_nxt;
   logic            r_squash, w_squash_nxt;
   logic            r_imem_req, w_imem_req_nxt;
   logic            r_if_valid, w_if_valid_nxt;
   logic [XLEN-1:0] r_if_instr, w_if_instr_nxt;
   logic [XLEN-1:0] r_if_pc, w_if_pc_nxt;
   logic [XLEN-1:0] r_if_pc_plus4, w_if_pc_plus4_nxt;
   logic            r_misalign, w_misalign_nxt;

   logic [XLEN-1:0] w_pc_seq;
   logic [XLEN-1:0] w_pc_target;
   logic            w_misalign;

   fetch_pc_next u_pc_next (
      .i_pc            (r_pc),
      .i_branch_taken  (branch_taken),
      .i_branch_target (branch_target),
      .o_pc_seq_c      (w_pc_seq),
      .o_pc_target_c   (w_pc_target),
      .o_misalign_c    (w_misalign)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state, PC select, squash tracking and decode-side capture.
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_squash_nxt      = r_squash;
      w_if_valid_nxt    = r_if_valid;
      w_if_instr_nxt    = r_if_instr;
      w_if_pc_nxt       = r_if_pc;
      w_if_pc_plus4_nxt = r_if_pc_plus4;
      w_misalign_nxt    = r_misalign | w_misalign;

      if (branch_taken) w_pc_nxt = w_pc_target;

      case (r_state)
         IDLE: begin
            if (!branch_taken) w_state_nxt = REQ;
         end
         REQ: begin
            // A redirect racing the grant leaves a wrong-path fetch in flight.
            if (imem.imem_gnt) begin
               w_state_nxt  = WAIT;
               w_squash_nxt = branch_taken;
            end
         end
         WAIT: begin
            if (imem.imem_rvalid) begin
               if (branch_taken || r_squash) begin
                  w_squash_nxt = 1'b0;
                  w_state_nxt  = REQ;
               end else begin
                  w_if_instr_nxt    = imem.imem_rdata;
                  w_if_pc_nxt       = r_pc;
                  w_if_pc_plus4_nxt = w_pc_seq;
                  w_if_valid_nxt    = 1'b1;
                  w_pc_nxt          = w_pc_seq;
                  w_state_nxt       = OUT;
               end
            end else if (branch_taken) begin
               w_squash_nxt = 1'b1;
            end
         end
         OUT: begin
            // Redirect drops the wrong-path instruction even under stall.
            if (branch_taken || !stall) begin
               w_if_valid_nxt = 1'b0;
               w_state_nxt    = REQ;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      w_imem_req_nxt = (w_state_nxt == REQ);
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_squash      <= 1'b0;
         r_imem_req    <= 1'b0;
         r_if_valid    <= 1'b0;
         r_if_instr    <= NOP_WORD;
         r_if_pc       <= '0;
         r_if_pc_plus4 <= '0;
         r_misalign    <= 1'b0;
      end else begin
         r_pc          <= w_pc_nxt;
         r_squash      <= w_squash_nxt;
         r_imem_req    <= w_imem_req_nxt;
         r_if_valid    <= w_if_valid_nxt;
         r_if_instr    <= w_if_instr_nxt;
         r_if_pc       <= w_if_pc_nxt;
         r_if_pc_plus4 <= w_if_pc_plus4_nxt;
         r_misalign    <= w_misalign_nxt;
      end
   end

   assign imem.imem_req  = r_imem_req;
   assign imem.imem_addr = r_pc;
   assign if_valid       = r_if_valid;
   assign if_instr       = r_if_instr;
   assign if_pc          = r_if_pc;
   assign if_pc_plus4    = r_if_pc_plus4;
   assign misalign_err   = r_misalign;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: two instances (RESET_PC 0 and FFFF_FFFC), a
// transaction-level reference model per instance and directed stimulus.
module tb_fetch_controller;

   localparam logic [31:0] K = 32'hA5A5_A5A5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- instance 0 (RESET_PC = 0) ----------------
   fetch_if if0 ();
   logic        br0 = 1'b0, stall0 = 1'b0;
   logic [31:0] tgt0 = '0;
   logic        v0, err0;
   logic [31:0] ins0, pc0, p40;

   fetch_controller #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut0 (
      .clk(clk), .rst(rst), .branch_taken(br0), .branch_target(tgt0), .stall(stall0),
      .imem(if0.master), .if_valid(v0), .if_instr(ins0), .if_pc(pc0),
      .if_pc_plus4(p40), .misalign_err(err0));

   // ---------------- instance 1 (RESET_PC = FFFF_FFFC) ----------------
   fetch_if if1 ();
   logic        v1, err1;
   logic [31:0] ins1, pc1, p41;

   fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .NOP_WORD(32'h0000_0013)) dut1 (
      .clk(clk), .rst(rst), .branch_taken(1'b0), .branch_target(32'h0), .stall(1'b0),
      .imem(if1.master), .if_valid(v1), .if_instr(ins1), .if_pc(pc1),
      .if_pc_plus4(p41), .misalign_err(err1));

   // ---------------- memory responders (not reset: late data must be ignored by DUT) ----
   logic        gnt_en0 = 1'b1;
   int          rv_delay0 = 1;
   logic        rv0 = 1'b0, busy0 = 1'b0;
   int          cnt0 = 0;
   logic [31:0] rd0 = '0, ad0 = '0;
   logic [31:0] gnt_q0[$];

   assign if0.imem_gnt    = if0.imem_req & gnt_en0;
   assign if0.imem_rvalid = rv0;
   assign if0.imem_rdata  = rd0;

   always @(posedge clk) begin
      rv0 <= 1'b0;
      if (busy0) begin
         if (cnt0 <= 1) begin
            rv0   <= 1'b1;
            rd0   <= ad0 ^ K;
            busy0 <= 1'b0;
         end else begin
            cnt0 <= cnt0 - 1;
         end
      end
      if (if0.imem_req && if0.imem_gnt) begin
         gnt_q0.push_back(if0.imem_addr);
         if (rv_delay0 <= 1) begin
            rv0 <= 1'b1;
            rd0 <= if0.imem_addr ^ K;
         end else begin
            busy0 <= 1'b1;
            cnt0  <= rv_delay0 - 1;
            ad0   <= if0.imem_addr;
         end
      end
   end

   logic        rv1 = 1'b0;
   logic [31:0] rd1 = '0;
   logic [31:0] gnt_q1[$];

   assign if1.imem_gnt    = if1.imem_req;
   assign if1.imem_rvalid = rv1;
   assign if1.imem_rdata  = rd1;

   always @(posedge clk) begin
      rv1 <= if1.imem_req & if1.imem_gnt;
      rd1 <= if1.imem_addr ^ K;
      if (if1.imem_req && if1.imem_gnt) gnt_q1.push_back(if1.imem_addr);
   end

   // ---------------- reference model ----------------
   // Abstract view: a pending request, an outstanding fetch (possibly doomed),
   // or an instruction being presented; otherwise the fetcher is idle.
   typedef struct {
      logic [31:0] pc;
      bit          req;
      bit          wt;
      bit          hold;
      bit          sq;
      bit          err;
      logic [31:0] instr;
      logic [31:0] ipc;
   } mdl_t;

   function automatic mdl_t mdl_reset(input logic [31:0] rpc);
      mdl_t m;
      m.pc = rpc; m.req = 0; m.wt = 0; m.hold = 0; m.sq = 0; m.err = 0;
      m.instr = '0; m.ipc = '0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t m, input bit br, input logic [31:0] tgt,
                                     input bit stl, input bit gnt, input bit rv,
                                     input logic [31:0] rd);
      mdl_t n;
      n = m;
      if (br) begin
         n.pc = tgt & 32'hFFFF_FFFC;
         if ((tgt & 32'h3) != 0) n.err = 1;
      end
      if (m.hold) begin
         if (br || !stl) begin n.hold = 0; n.req = 1; end
      end else if (m.wt) begin
         if (rv) begin
            n.wt = 0;
            if (br || m.sq) begin
               n.sq = 0; n.req = 1;
            end else begin
               n.instr = rd; n.ipc = m.pc; n.pc = m.pc + 32'd4; n.hold = 1;
            end
         end else if (br) begin
            n.sq = 1;
         end
      end else if (m.req) begin
         if (gnt) begin n.req = 0; n.wt = 1; n.sq = br; end
      end else if (!br) begin
         n.req = 1;
      end
      return n;
   endfunction

   mdl_t m0, m1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m0 <= mdl_reset(32'h0000_0000);
         m1 <= mdl_reset(32'hFFFF_FFFC);
      end else begin
         m0 <= mdl_step(m0, br0, tgt0, stall0, gnt_en0 & m0.req, rv0, rd0);
         m1 <= mdl_step(m1, 1'b0, 32'h0, 1'b0, m1.req, rv1, rd1);
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(input string t, input mdl_t m, input logic req,
                          input logic [31:0] addr, input logic v, input logic [31:0] ins,
                          input logic [31:0] pc, input logic [31:0] p4, input logic err);
      chk({t, ".imem_req"}, 32'(req), 32'(m.req));
      if (m.req) chk({t, ".imem_addr"}, addr, m.pc);
      chk({t, ".if_valid"}, 32'(v), 32'(m.hold));
      if (m.hold) begin
         chk({t, ".if_instr"}, ins, m.instr);
         chk({t, ".if_pc"}, pc, m.ipc);
         chk({t, ".if_pc_plus4"}, p4, m.ipc + 32'd4);
      end
      chk({t, ".misalign_err"}, 32'(err), 32'(m.err));
   endtask

   logic        pv0 = 1'b0, pv1 = 1'b0;
   logic [31:0] pres_pc0[$], pres_ins0[$], pres_p40[$];
   logic [31:0] pres_pc1[$], pres_p41[$];

   // Every-cycle comparison against the model, plus presentation logging.
   always @(negedge clk) begin
      cmp_dut("d0", m0, if0.imem_req, if0.imem_addr, v0, ins0, pc0, p40, err0);
      cmp_dut("d1", m1, if1.imem_req, if1.imem_addr, v1, ins1, pc1, p41, err1);
      if (v0 && !pv0) begin
         pres_pc0.push_back(pc0); pres_ins0.push_back(ins0); pres_p40.push_back(p40);
      end
      if (v1 && !pv1) begin
         pres_pc1.push_back(pc1); pres_p41.push_back(p41);
      end
      pv0 <= v0;
      pv1 <= v1;
   end

   task automatic wait_gnt0(input int n);
      int k;
      k = 0;
      while (gnt_q0.size() < n && k < 80) begin
         @(negedge clk);
         k++;
      end
      chk("wait_grant_count", 32'(gnt_q0.size() >= n), 32'd1);
      #1;
   endtask

   task automatic wait_req0();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!if0.imem_req && k < 40);
      chk("wait_req", 32'(if0.imem_req), 32'd1);
      #1;
   endtask

   task automatic pulse_br0(input logic [31:0] t);
      br0  = 1'b1;
      tgt0 = t;
      @(negedge clk);
      br0  = 1'b0;
      tgt0 = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int n;
      int pn;

      // Reset values.
      repeat (3) @(negedge clk);
      #1;
      chk("rst.imem_req", 32'(if0.imem_req), 32'd0);
      chk("rst.if_valid", 32'(v0), 32'd0);
      chk("rst.if_instr", ins0, 32'h0000_0000);
      chk("rst.if_pc", pc0, 32'h0);
      chk("rst.if_pc_plus4", p40, 32'h0);
      chk("rst.misalign", 32'(err0), 32'd0);
      chk("rst.d1_if_instr", ins1, 32'h0000_0013);

      // First request one cycle after release.
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("first_req", 32'(if0.imem_req), 32'd1);
      chk("first_addr", if0.imem_addr, 32'h0);

      // Run to the presentation of pc 8, then stall for 5 cycles.
      k = 0;
      while (!(m0.hold && m0.ipc == 32'h8) && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("reach_pc8", 32'(m0.hold && m0.ipc == 32'h8), 32'd1);
      stall0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("stall.if_valid", 32'(v0), 32'd1);
         chk("stall.if_pc", pc0, 32'h8);
         chk("stall.imem_req", 32'(if0.imem_req), 32'd0);
      end

      chk("seq.pres_count", 32'(pres_ins0.size() >= 3), 32'd1);
      if (pres_ins0.size() >= 3) begin
         chk("seq.instr0", pres_ins0[0], 32'hA5A5_A5A5);
         chk("seq.instr1", pres_ins0[1], 32'hA5A5_A5A1);
         chk("seq.instr2", pres_ins0[2], 32'hA5A5_A5AD);
         chk("seq.plus4_0", pres_p40[0], 32'h4);
         chk("seq.plus4_2", pres_p40[2], 32'hC);
      end

      // Wrap-around instance.
      chk("wrap.grants", 32'(gnt_q1.size() >= 2), 32'd1);
      if (gnt_q1.size() >= 2) begin
         chk("wrap.addr0", gnt_q1[0], 32'hFFFF_FFFC);
         chk("wrap.addr1", gnt_q1[1], 32'h0000_0000);
      end
      if (pres_pc1.size() >= 1) begin
         chk("wrap.if_pc", pres_pc1[0], 32'hFFFF_FFFC);
         chk("wrap.plus4", pres_p41[0], 32'h0000_0000);
      end else begin
         chk("wrap.pres_count", 32'(pres_pc1.size()), 32'd1);
      end

      // Release stall; next fetch at 12 with slow memory, redirect in WAIT.
      stall0    = 1'b0;
      rv_delay0 = 3;
      wait_gnt0(4);
      chk("seq.addr3", gnt_q0[3], 32'hC);
      pulse_br0(32'h0000_0100);
      rv_delay0 = 1;
      wait_gnt0(5);
      chk("wait_redir.addr", gnt_q0[4], 32'h100);
      chk("wait_redir.dropped", 32'(pres_ins0.size()), 32'd3);

      // Redirect coinciding with a grant.
      wait_req0();
      pulse_br0(32'h0000_0200);
      wait_gnt0(7);
      chk("gnt_redir.squashed_addr", gnt_q0[5], 32'h104);
      chk("gnt_redir.addr", gnt_q0[6], 32'h200);
      chk("gnt_redir.dropped", 32'(pres_ins0.size()), 32'd4);
      chk("gnt_redir.misalign", 32'(err0), 32'd0);

      // Same with a misaligned target.
      wait_req0();
      pulse_br0(32'h0000_0203);
      wait_gnt0(9);
      chk("misalign.addr", gnt_q0[8], 32'h200);
      chk("misalign.flag", 32'(err0), 32'd1);
      chk("misalign.dropped", 32'(pres_ins0.size()), 32'd5);
      repeat (10) @(negedge clk);
      #1;
      chk("misalign.sticky", 32'(err0), 32'd1);

      // Asynchronous reset during WAIT; late response arrives under reset.
      rv_delay0 = 3;
      wait_req0();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("arst.imem_req", 32'(if0.imem_req), 32'd0);
      chk("arst.if_valid", 32'(v0), 32'd0);
      chk("arst.misalign", 32'(err0), 32'd0);
      chk("arst.if_instr", ins0, 32'h0000_0000);
      repeat (3) @(negedge clk);
      rv_delay0 = 1;
      n  = gnt_q0.size();
      pn = pres_pc0.size();
      rst = 1'b0;
      wait_gnt0(n + 1);
      chk("arst.restart_addr", gnt_q0[n], 32'h0);
      k = 0;
      while (pres_pc0.size() <= pn && k < 20) begin
         @(negedge clk);
         k++;
      end
      #1;
      chk("arst.pres_count", 32'(pres_pc0.size() > pn), 32'd1);
      if (pres_pc0.size() > pn) begin
         chk("arst.if_pc", pres_pc0[pn], 32'h0);
         chk("arst.if_instr", pres_ins0[pn], 32'hA5A5_A5A5);
      end

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
